// File: rtl/wb_imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wb_imem_loader
// Purpose  : Wishbone slave that loads a core's instruction SRAM and controls
//            the core's run enable and reset. Optional cycle counter enabled
//            by defining WB_IMEM_CYCLE_COUNTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_imem_loader #(
    parameter int          IMEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    localparam int         AW         = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          wbs_stb_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic          imem_en,
    output logic [3:0]    imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    input  logic [31:0]   imem_rdata,
    output logic          core_run,
    output logic          core_rst_n
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MEMRD = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    localparam logic [29:0] C_IMEM_WBASE = 30'h400;
    localparam logic [29:0] C_IMEM_WEND  = C_IMEM_WBASE + 30'(IMEM_WORDS);

    state_t      r_state;
    logic        r_ack;
    logic [31:0] r_dat;
    logic        r_run;
    logic        r_wr_blocked;
    logic        r_core_rst_n;
    logic [1:0]  r_srst_cnt;

    logic [29:0] w_woff;
    logic        w_unused;
    logic        w_req;
    logic        w_sel_ctrl;
    logic        w_sel_status;
    logic        w_sel_cycles;
    logic        w_sel_imem;
    logic        w_imem_wr;
    logic        w_imem_rd;
    logic        w_blocked_set;
    logic        w_status_clr;
    logic        w_ctrl_wr;
    logic        w_soft_rst;
    logic [31:0] w_cycles;
    logic [31:0] w_rdval;

    // Word offset from the block base; byte lanes are selected by wbs_sel_i.
    assign w_woff   = wbs_adr_i[31:2] - BASE_ADDR[31:2];
    assign w_unused = ^wbs_adr_i[1:0];

    assign w_sel_ctrl   = (w_woff == 30'd0);
    assign w_sel_status = (w_woff == 30'd1);
    assign w_sel_cycles = (w_woff == 30'd2);
    assign w_sel_imem   = (w_woff >= C_IMEM_WBASE) && (w_woff < C_IMEM_WEND);

    // Gated by reset so the SRAM is never strobed while the block is held.
    assign w_req = wbs_stb_i & wbs_cyc_i & (r_state == S_IDLE) & wb_rst_ni;

    assign w_imem_wr     = w_req & w_sel_imem & wbs_we_i & ~r_run;
    assign w_imem_rd     = w_req & w_sel_imem & ~wbs_we_i;
    assign w_blocked_set = w_req & w_sel_imem & wbs_we_i & r_run;
    assign w_ctrl_wr     = w_req & wbs_we_i & w_sel_ctrl & wbs_sel_i[0];
    assign w_soft_rst    = w_ctrl_wr & wbs_dat_i[1];
    assign w_status_clr  = w_req & wbs_we_i & w_sel_status & wbs_sel_i[0] & wbs_dat_i[1];

    assign imem_en    = w_imem_wr | w_imem_rd;
    assign imem_we    = w_imem_wr ? wbs_sel_i : 4'h0;
    assign imem_addr  = w_woff[AW-1:0];
    assign imem_wdata = wbs_dat_i;

    assign wbs_ack_o  = r_ack;
    assign wbs_dat_o  = r_dat;
    assign core_run   = r_run;
    assign core_rst_n = r_core_rst_n;

    always_comb begin
        w_rdval = 32'h0;
        if (w_sel_ctrl) begin
            w_rdval = {31'h0, r_run};
        end else if (w_sel_status) begin
            w_rdval = {29'h0, ~r_core_rst_n, r_wr_blocked, r_run};
        end else if (w_sel_cycles) begin
            w_rdval = w_cycles;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_dat   <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= 1'b0;
                    if (w_req) begin
                        if (w_sel_imem && !wbs_we_i) begin
                            r_state <= S_MEMRD;
                        end else begin
                            r_state <= S_ACK;
                            r_ack   <= 1'b1;
                            if (!wbs_we_i) begin
                                r_dat <= w_rdval;
                            end
                        end
                    end
                end
                S_MEMRD: begin
                    // Master abandoned the cycle: drop it silently.
                    if (!wbs_cyc_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_dat   <= imem_rdata;
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    r_ack   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    // Soft-reset pulse: low on the acceptance edge plus three more edges.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_run        <= 1'b0;
            r_wr_blocked <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_srst_cnt   <= 2'd0;
        end else begin
            if (w_ctrl_wr) begin
                r_run <= wbs_dat_i[0];
            end
            if (w_blocked_set) begin
                r_wr_blocked <= 1'b1;
            end else if (w_status_clr) begin
                r_wr_blocked <= 1'b0;
            end
            if (w_soft_rst) begin
                r_core_rst_n <= 1'b0;
                r_srst_cnt   <= 2'd3;
            end else if (r_srst_cnt != 2'd0) begin
                r_srst_cnt <= r_srst_cnt - 2'd1;
            end else begin
                r_core_rst_n <= 1'b1;
            end
        end
    end

`ifdef WB_IMEM_CYCLE_COUNTER_EN
    logic [31:0] r_cycles;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni || !r_core_rst_n) begin
            r_cycles <= 32'h0;
        end else if (r_run) begin
            r_cycles <= r_cycles + 32'h1;
        end
    end

    assign w_cycles = r_cycles;
`else
    assign w_cycles = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wb_imem_loader
// Purpose  : Directed plus randomized bench for wb_imem_loader with an SRAM
//            model and a word-level reference memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_imem_loader;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_CYC  = BASE + 32'h8;
    localparam logic [31:0] A_MEM  = BASE + 32'h1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i;
    logic        ack;
    logic [31:0] dat_o;
    logic        imem_en;
    logic [3:0]  imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [31:0] imem_rdata;
    logic        core_run;
    logic        core_rst_n;

    always #5 clk = ~clk;

    wb_imem_loader dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_i),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_o),
        .imem_en    (imem_en),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_rdata (imem_rdata),
        .core_run   (core_run),
        .core_rst_n (core_rst_n)
    );

    logic [31:0] sram    [1024] = '{default: 32'h0};
    logic [31:0] ref_mem [1024] = '{default: 32'h0};

    // Synchronous SRAM with byte enables, one-cycle read latency.
    always @(posedge clk) begin
        if (imem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (imem_we[b]) sram[imem_addr][8*b +: 8] <= imem_wdata[8*b +: 8];
            end
            imem_rdata <= sram[imem_addr];
        end
    end

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int checks = 0;
    int errors = 0;
    int last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd, output int lat,
                        output logic p_en, output logic [3:0] p_we, output logic [9:0] p_addr);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
        last_acc = edge_n + 1;
        #1;
        p_en = imem_en; p_we = imem_we; p_addr = imem_addr;
        lat = 0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (ack) break;
        end
        if (!ack) lat = -1;
        rd = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, d, e;
        logic [3:0]  s, pwe;
        logic [9:0]  pa;
        logic        pen, m_run, m_blk;
        logic [5:0]  pat;
        int          lat, idx, ea, eb;

        rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat_i = 32'h0;
        m_run = 1'b0; m_blk = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'h0, ack}, 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_imem_en", {31'h0, imem_en}, 32'h0);
        chk("rst_imem_we", {28'h0, imem_we}, 32'h0);
        chk("rst_core_run", {31'h0, core_run}, 32'h0);
        chk("rst_core_rst_n", {31'h0, core_rst_n}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_core_rst_n", {31'h0, core_rst_n}, 32'h1);
        xfer(1'b0, A_STAT, 4'hF, 32'h0, rd, lat, pen, pwe, pa);
        chk("init_status", rd, 32'h0);

        // IMEM write then read-back, core halted
        xfer(1'b1, A_MEM + 32'h4, 4'hF, 32'hDEADBEEF, rd, lat, pen, pwe, pa);
        ref_mem[1] = 32'hDEADBEEF;
        chk("wr_lat", 32'(lat), 32'd1);
        chk("wr_en", {31'h0, pen}, 32'h1);
        chk("wr_we", {28'h0, pwe}, 32'hF);
        chk("wr_addr", {22'h0, pa}, 32'h1);
        @(negedge clk);
        chk("ack_one_cycle", {31'h0, ack}, 32'h0);
        xfer(1'b0, A_MEM + 32'h4, 4'hF, 32'h0, rd, lat, pen, pwe, pa);
        chk("rd_lat", 32'(lat), 32'd2);
        chk("rd_en", {31'h0, pen}, 32'h1);
        chk("rd_we", {28'h0, pwe}, 32'h0);
        chk("rd_addr", {22'h0, pa}, 32'h1);
        chk("rd_data", rd, 32'hDEADBEEF);

        // Unmapped address
        xfer(1'b0, BASE + 32'h10, 4'hF, 32'h0, rd, lat, pen, pwe, pa);
        chk("unmap_lat", 32'(lat), 32'd1);
        chk("unmap_data", rd, 32'h0);
        xfer(1'b1, BASE + 32'h10, 4'hF, 32'hFFFF_FFFF, rd, lat, pen, pwe, pa);
        chk("unmap_wr_lat", 32'(lat), 32'd1);
        chk("unmap_wr_en", {31'h0, pen}, 32'h0);
        xfer(1'b0, A_CTRL, 4'hF, 32'h0, rd, lat, pen, pwe, pa);
        chk("unmap_ctrl", rd, 32'h0);
        xfer(1'b0, A_STAT, 4'hF, 32'h0, rd, lat, pen, pwe, pa);
        chk("unmap_status", rd, 32'h0);
        xfer(1'b0, A_CYC, 4'hF, 32'h0, rd, lat, pen, pwe, pa);
        chk("cycles_idle", rd, 32'h0);

        // Write blocked while running, sticky flag, byte-lane-0 gating
        xfer(1'b1, A_CTRL, 4'hF, 32'h1, rd, lat, pen, pwe, pa);
        chk("core_run_on", {31'h0, core_run}, 32'h1);
        xfer(1'b1, A_MEM, 4'hF, 32'h1234_5678, rd, lat, pen, pwe, pa);
        chk("blk_lat", 32'(lat), 32'd1);
        chk("blk_en", {31'h0, pen}, 32'h0);
        chk("blk_we", {28'h0, pwe}, 32'h0);
        xfer(1'b0, A_STAT, 4'hF, 32'h0, rd, lat, pen, pwe, pa);
        chk("blk_status", rd, 32'h3);
        xfer(1'b0, A_MEM, 4'hF, 32'h0, rd, lat, pen, pwe, pa);
        chk("run_rd_data", rd, ref_mem[0]);
        xfer(1'b1, A_STAT, 4'hE, 32'h2, rd, lat, pen, pwe, pa);
        xfer(1'b0, A_STAT, 4'hF, 32'h0, rd, lat, pen, pwe, pa);
        chk("clr_nosel0", rd, 32'h3);
        xfer(1'b1, A_STAT, 4'hF, 32'h2, rd, lat, pen, pwe, pa);
        xfer(1'b0, A_STAT, 4'hF, 32'h0, rd, lat, pen, pwe, pa);
        chk("clr_status", rd, 32'h1);
        xfer(1'b1, A_CTRL, 4'hE, 32'h0, rd, lat, pen, pwe, pa);
        xfer(1'b0, A_CTRL, 4'hF, 32'h0, rd, lat, pen, pwe, pa);
        chk("ctrl_nosel0", rd, 32'h1);
        m_run = 1'b1;

        // Randomized traffic against the reference model
        for (int it = 0; it < 80; it++) begin
            idx = $urandom_range(0, 15);
            d   = $urandom;
            s   = 4'($urandom_range(1, 15));
            case ($urandom_range(0, 5))
                0, 1: begin
                    xfer(1'b1, A_MEM + 32'(4 * idx), s, d, rd, lat, pen, pwe, pa);
                    chk("rnd_wr_lat", 32'(lat), 32'd1);
                    chk("rnd_wr_en", {31'h0, pen}, {31'h0, ~m_run});
                    chk("rnd_wr_we", {28'h0, pwe}, m_run ? 32'h0 : {28'h0, s});
                    if (m_run) m_blk = 1'b1;
                    else for (int b = 0; b < 4; b++)
                        if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
                end
                2, 3: begin
                    xfer(1'b0, A_MEM + 32'(4 * idx), 4'hF, 32'h0, rd, lat, pen, pwe, pa);
                    chk("rnd_rd_lat", 32'(lat), 32'd2);
                    chk("rnd_rd_data", rd, ref_mem[idx]);
                end
                4: begin
                    xfer(1'b1, A_CTRL, 4'hF, {31'h0, d[0]}, rd, lat, pen, pwe, pa);
                    m_run = d[0];
                end
                default: begin
                    if (d[4]) begin
                        xfer(1'b1, A_STAT, s, 32'h2, rd, lat, pen, pwe, pa);
                        if (s[0]) m_blk = 1'b0;
                    end
                    xfer(1'b0, A_STAT, 4'hF, 32'h0, rd, lat, pen, pwe, pa);
                    chk("rnd_status", rd, {30'h0, m_blk, m_run});
                end
            endcase
        end
        xfer(1'b1, A_CTRL, 4'hF, 32'h0, rd, lat, pen, pwe, pa);
        xfer(1'b1, A_STAT, 4'hF, 32'h2, rd, lat, pen, pwe, pa);
        m_run = 1'b0; m_blk = 1'b0;

        // Soft-reset pulse width
        xfer(1'b1, A_CTRL, 4'hF, 32'h2, rd, lat, pen, pwe, pa);
        pat[0] = core_rst_n;
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            pat[i] = core_rst_n;
        end
        chk("srst_pulse", {26'h0, pat}, 32'h30);
        xfer(1'b1, A_CTRL, 4'hF, 32'h2, rd, lat, pen, pwe, pa);
        xfer(1'b0, A_STAT, 4'hF, 32'h0, rd, lat, pen, pwe, pa);
        chk("srst_status", rd, 32'h4);
        repeat (5) @(negedge clk);
        xfer(1'b0, A_STAT, 4'hF, 32'h0, rd, lat, pen, pwe, pa);
        chk("srst_done_status", rd, 32'h0);
        xfer(1'b0, A_CYC, 4'hF, 32'h0, rd, lat, pen, pwe, pa);
        chk("srst_cycles", rd, 32'h0);

        // Cycle counter: run with a soft reset, then stop
        xfer(1'b1, A_CTRL, 4'hF, 32'h3, rd, lat, pen, pwe, pa);
        ea = last_acc;
        repeat (102) @(negedge clk);
        xfer(1'b1, A_CTRL, 4'hF, 32'h0, rd, lat, pen, pwe, pa);
        eb = last_acc;
        xfer(1'b0, A_CYC, 4'hF, 32'h0, rd, lat, pen, pwe, pa);
`ifdef WB_IMEM_CYCLE_COUNTER_EN
        e = 32'(eb - ea - 4);
`else
        e = 32'h0;
`endif
        chk("cycles_count", rd, e);

        // Master drops cyc during an IMEM read
        xfer(1'b0, A_CTRL, 4'hF, 32'h0, rd, lat, pen, pwe, pa);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_MEM + 32'h4; sel = 4'hF;
        @(negedge clk);
        chk("drop_ack_memrd", {31'h0, ack}, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("drop_ack_idle", {31'h0, ack}, 32'h0);
        chk("drop_dat_kept", dat_o, 32'h0);
        @(negedge clk);
        chk("drop_ack_late", {31'h0, ack}, 32'h0);
        xfer(1'b0, A_MEM + 32'h4, 4'hF, 32'h0, rd, lat, pen, pwe, pa);
        chk("drop_next_lat", 32'(lat), 32'd2);
        chk("drop_next_data", rd, ref_mem[1]);

        // Reset asserted during MEMRD
        xfer(1'b1, A_CTRL, 4'hF, 32'h1, rd, lat, pen, pwe, pa);
        xfer(1'b1, A_MEM, 4'hF, 32'h5555_AAAA, rd, lat, pen, pwe, pa);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_MEM + 32'h4; sel = 4'hF;
        @(negedge clk);
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("mrst_ack", {31'h0, ack}, 32'h0);
        chk("mrst_dat", dat_o, 32'h0);
        chk("mrst_imem_en", {31'h0, imem_en}, 32'h0);
        chk("mrst_imem_we", {28'h0, imem_we}, 32'h0);
        chk("mrst_core_run", {31'h0, core_run}, 32'h0);
        chk("mrst_core_rst_n", {31'h0, core_rst_n}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_rel_rst_n", {31'h0, core_rst_n}, 32'h1);
        xfer(1'b0, A_STAT, 4'hF, 32'h0, rd, lat, pen, pwe, pa);
        chk("mrst_status", rd, 32'h0);
        xfer(1'b0, A_CYC, 4'hF, 32'h0, rd, lat, pen, pwe, pa);
        chk("mrst_cycles", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
